// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite draw path.
package draw_pkg;

    localparam int unsigned SPRITE_DIM = 32;
    localparam int unsigned POS_W      = 10;
    localparam int unsigned DIR_W      = 6;

    // Arbiter control states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_ACK    = 3'd4
    } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: first asserted request at or after rr_ptr_i,
// wrapping modulo NUM_REQ.
//   req_i        request vector
//   rr_ptr_i     highest-priority index this round
//   win_oh_c_o   one-hot winner (zero when nothing requested)
//   win_idx_c_o  winner index
//   valid_c_o    at least one request present
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] win_oh_c_o,
    output logic [IDX_W-1:0]   win_idx_c_o,
    output logic               valid_c_o
);

    // Scan from the farthest offset down so the nearest-to-pointer request wins last.
    always_comb begin
        int unsigned pos;
        pos         = 0;
        win_idx_c_o = '0;
        valid_c_o   = 1'b0;
        win_oh_c_o  = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            pos = 32'(rr_ptr_i) + 32'(k);
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req_i[IDX_W'(pos)]) begin
                win_idx_c_o = IDX_W'(pos);
                valid_c_o   = 1'b1;
            end
        end
        if (valid_c_o) begin
            win_oh_c_o = NUM_REQ'(1) << win_idx_c_o;
        end
    end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter sharing one sprite draw engine among NUM_REQ requesters.
// Latches the winner's position/direction/erase, launches one draw, waits for
// eng_done or a watchdog timeout, then acks the winner.
//   clk, reset_n                  clock, synchronous active-low reset
//   req / req_x / req_y / req_dir / req_erase   per-requester level request + packed payload
//   eng_done                      engine completion pulse
//   gnt / ack                     one-hot owner and one-cycle completion pulse
//   eng_start, eng_x/y/dir/erase  engine launch pulse and latched payload
//   busy, timeout_err             not-idle flag, sticky watchdog expiry flag
module sprite_draw_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned POS_W   = draw_pkg::POS_W,
    parameter int unsigned DIR_W   = draw_pkg::DIR_W,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*POS_W-1:0] req_x,
    input  logic [NUM_REQ*POS_W-1:0] req_y,
    input  logic [NUM_REQ*DIR_W-1:0] req_dir,
    input  logic [NUM_REQ-1:0]       req_erase,
    input  logic                     eng_done,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     eng_start,
    output logic [POS_W-1:0]         eng_x,
    output logic [POS_W-1:0]         eng_y,
    output logic [DIR_W-1:0]         eng_dir,
    output logic                     eng_erase,
    output logic                     busy,
    output logic                     timeout_err
);
    import draw_pkg::*;

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 start_q, start_d;
    logic [POS_W-1:0]     x_q, x_d;
    logic [POS_W-1:0]     y_q, y_d;
    logic [DIR_W-1:0]     dir_q, dir_d;
    logic                 erase_q, erase_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    logic [NUM_REQ-1:0]   pick_oh_c;
    logic [IDX_W-1:0]     pick_idx_c;
    logic                 pick_valid_c;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .win_oh_c_o  (pick_oh_c),
        .win_idx_c_o (pick_idx_c),
        .valid_c_o   (pick_valid_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        start_d  = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        erase_d  = erase_q;
        err_d    = err_q;
        wdog_d   = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                // Requests may have vanished since IDLE; fall back without a grant.
                if (pick_valid_c) begin
                    state_d = S_LAUNCH;
                    win_d   = pick_idx_c;
                    gnt_d   = pick_oh_c;
                    start_d = 1'b1;
                    x_d     = req_x[32'(pick_idx_c) * POS_W +: POS_W];
                    y_d     = req_y[32'(pick_idx_c) * POS_W +: POS_W];
                    dir_d   = req_dir[32'(pick_idx_c) * DIR_W +: DIR_W];
                    erase_d = req_erase[pick_idx_c];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // Completion wins over a coincident watchdog expiry.
                if (eng_done || (wdog_q == WDOG_W'(TIMEOUT - 1))) begin
                    state_d  = S_ACK;
                    ack_d    = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                    if (!eng_done) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= '0;
            erase_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            erase_q  <= erase_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign eng_start   = start_q;
    assign eng_x       = x_q;
    assign eng_y       = y_q;
    assign eng_dir     = dir_q;
    assign eng_erase   = erase_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule
